// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined SIMD carry-lookahead adder.
// Pure definitions; no logic, no latency, no flow control.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_EIGHTH  = 2'd3
  } mode_e;

  localparam int MIN_LANES = 8;
  localparam int GROUP_W   = 8;

  // True when bit position b starts a lane for the given mode and total width.
  function automatic logic lane_start(input int b, input mode_e m, input int width);
    int lw;
    lw = width >> m;
    return (b % lw) == 0;
  endfunction

endpackage

// File: rtl/cla_group8.sv
// 8-bit carry-lookahead group with per-bit lane-boundary carry override.
// Purely combinational; no latency, no flow control.
module cla_group8
  import adder_pkg::*;
(
  input  logic [GROUP_W-1:0] i_g,
  input  logic [GROUP_W-1:0] i_p,
  input  logic [GROUP_W-1:0] i_bnd,
  input  logic               i_cin,
  input  logic               i_lane_c,
  output logic [GROUP_W-1:0] o_c,
  output logic               o_cout
);

  logic [GROUP_W-1:0] w_gx;
  logic [GROUP_W-1:0] w_px;
  logic [GROUP_W:0]   w_rc;

  // A boundary bit kills the incoming chain and injects the lane carry-in.
  assign w_gx = i_g | (i_p & i_bnd & {GROUP_W{i_lane_c}});
  assign w_px = i_p & ~i_bnd;

  always_comb begin : p_lookahead
    logic pp;
    pp   = 1'b1;
    w_rc = '0;
    for (int i = 0; i <= GROUP_W; i++) begin
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        w_rc[i] = w_rc[i] | (pp & w_gx[j]);
        pp      = pp & w_px[j];
      end
      w_rc[i] = w_rc[i] | (pp & i_cin);
    end
  end

  assign o_c    = (i_bnd & {GROUP_W{i_lane_c}}) | (~i_bnd & w_rc[GROUP_W-1:0]);
  assign o_cout = w_rc[GROUP_W];

endmodule

// File: rtl/pipelined_simd_cla_adder.sv
// Pipelined SIMD adder: one SEG_W slice per stage, carry registered between stages; latency PIPE+... see below.
// Result valid PIPE cycles after accept; a stalled output freezes every stage and drops oReady.
module pipelined_simd_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int PIPE  = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  input  logic [1:0]       iMode,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic [7:0]       oC
);

  localparam int SEG_W      = WIDTH / PIPE;
  localparam int NG         = SEG_W / GROUP_W;
  localparam int LANE_MIN_W = WIDTH / MIN_LANES;

  // Index s of the operand/control arrays is the input of compute stage s.
  logic [PIPE:0]          r_vld;
  logic [WIDTH-1:0]       r_a    [PIPE];
  logic [WIDTH-1:0]       r_b    [PIPE];
  logic [PIPE-1:0]        r_ci;
  mode_e                  r_mode [PIPE];
  logic                   r_cy   [PIPE];
  logic [WIDTH-1:0]       r_sum  [PIPE];
  logic [MIN_LANES-1:0]   r_co   [PIPE];

  logic                   w_en;
  logic [SEG_W-1:0]       w_sum  [PIPE];
  logic [MIN_LANES-1:0]   w_co   [PIPE];
  logic [PIPE-1:0]        w_cout;

  assign w_en   = ~oValid | iReady;
  assign oReady = w_en;
  assign oValid = r_vld[PIPE];
  assign oSum   = r_sum[PIPE-1];
  assign oC     = r_co[PIPE-1];

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int LO = s * SEG_W;

    logic [SEG_W-1:0]     w_g;
    logic [SEG_W-1:0]     w_p;
    logic [SEG_W-1:0]     w_bnd;
    logic [SEG_W-1:0]     w_cf;
    logic [NG:0]          w_chain;
    logic [MIN_LANES-1:0] w_co_s;

    assign w_g = r_a[s][LO +: SEG_W] & r_b[s][LO +: SEG_W];
    assign w_p = r_a[s][LO +: SEG_W] ^ r_b[s][LO +: SEG_W];

    if (s == 0) begin : g_cin_first
      assign w_chain[0] = r_ci[0];
    end else begin : g_cin_reg
      assign w_chain[0] = r_cy[s-1];
    end

    for (genvar i = 0; i < SEG_W; i++) begin : g_bnd
      assign w_bnd[i] = lane_start(LO + i, r_mode[s], WIDTH);
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group8 u_grp (
        .i_g      (w_g[g*GROUP_W +: GROUP_W]),
        .i_p      (w_p[g*GROUP_W +: GROUP_W]),
        .i_bnd    (w_bnd[g*GROUP_W +: GROUP_W]),
        .i_cin    (w_chain[g]),
        .i_lane_c (r_ci[s]),
        .o_c      (w_cf[g*GROUP_W +: GROUP_W]),
        .o_cout   (w_chain[g+1])
      );
    end

    // Minimum-lane MSBs are always group MSBs, so a group carry-out is the lane carry-out.
    for (genvar j = 0; j < MIN_LANES; j++) begin : g_co
      localparam int MSB = (j + 1) * LANE_MIN_W - 1;
      if (MSB >= LO && MSB < LO + SEG_W) begin : g_here
        assign w_co_s[j] = lane_start(MSB + 1, r_mode[s], WIDTH)
                         & w_chain[(MSB - LO) / GROUP_W + 1];
      end else begin : g_other
        assign w_co_s[j] = 1'b0;
      end
    end

    assign w_sum[s]  = w_p ^ w_cf;
    assign w_co[s]   = w_co_s;
    assign w_cout[s] = w_chain[NG];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_vld <= '0;
      r_ci  <= '0;
      for (int s = 0; s < PIPE; s++) begin
        r_a[s]    <= '0;
        r_b[s]    <= '0;
        r_mode[s] <= MODE_FULL;
        r_cy[s]   <= 1'b0;
        r_sum[s]  <= '0;
        r_co[s]   <= '0;
      end
    end else if (w_en) begin
      r_vld     <= {r_vld[PIPE-1:0], iValid};
      r_a[0]    <= iA;
      r_b[0]    <= iB;
      r_ci[0]   <= iC;
      r_mode[0] <= mode_e'(iMode);
      for (int s = 1; s < PIPE; s++) begin
        r_a[s]    <= r_a[s-1];
        r_b[s]    <= r_b[s-1];
        r_ci[s]   <= r_ci[s-1];
        r_mode[s] <= r_mode[s-1];
      end
      for (int s = 0; s < PIPE; s++) begin
        r_cy[s] <= w_cout[s];
      end
      r_sum[0] <= WIDTH'(w_sum[0]);
      r_co[0]  <= w_co[0];
      for (int s = 1; s < PIPE; s++) begin
        r_sum[s]                    <= r_sum[s-1];
        r_sum[s][s*SEG_W +: SEG_W]  <= w_sum[s];
        r_co[s]                     <= r_co[s-1] | w_co[s];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_simd_cla_adder.sv
// Randomised plus directed bench for pipelined_simd_cla_adder against a lane-arithmetic model.
// Expected results are queued on accept and popped on consume.
module tb_pipelined_simd_cla_adder;

  typedef struct packed {
    logic [63:0] s;
    logic [7:0]  c;
  } res_t;

  logic        iClk = 1'b0;
  logic        iRst, iValid, oReady, iC, oValid, iReady;
  logic [63:0] iA, iB, oSum;
  logic [1:0]  iMode;
  logic [7:0]  oC;

  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  bit   mon_on = 0;
  bit   done = 0;
  res_t q[$];
  logic        held = 1'b0;
  logic [63:0] h_s;
  logic [7:0]  h_c;

  pipelined_simd_cla_adder #(.WIDTH(64), .PIPE(4)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iC(iC), .iMode(iMode),
    .oValid(oValid), .iReady(iReady), .oSum(oSum), .oC(oC)
  );

  always #5 iClk = ~iClk;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic [1:0] m);
    res_t        r;
    int          lw, nl;
    logic [63:0] mask, al, bl;
    logic [64:0] t;
    lw   = 64 >> m;
    nl   = 1 << m;
    mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    r    = '0;
    for (int l = 0; l < nl; l++) begin
      al  = (a >> (l * lw)) & mask;
      bl  = (b >> (l * lw)) & mask;
      t   = {1'b0, al} + {1'b0, bl} + {64'd0, ci};
      r.s = r.s | ((t[63:0] & mask) << (l * lw));
      r.c[(l + 1) * lw / 8 - 1] = t[lw];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic [1:0] m);
    bit acc;
    int n;
    iValid = 1'b1; iA = a; iB = b; iC = ci; iMode = m;
    n = 0;
    do begin
      @(negedge iClk);
      acc = oReady;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    iValid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic [1:0] m,
                         input logic [63:0] es, input logic [7:0] ec);
    int n;
    send(a, b, ci, m);
    n = 0;
    @(negedge iClk);
    while (!oValid && n < 20) begin
      @(negedge iClk);
      n++;
    end
    check({name, "_valid"}, oValid, 1'b1);
    check({name, "_latency"}, n, 4);
    check({name, "_sum"}, oSum, es);
    check({name, "_carry"}, oC, ec);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Scoreboard: compare, hold-check during stalls, then apply this cycle's accept/consume.
  initial begin
    forever begin
      @(negedge iClk);
      if (mon_on) begin
        if (held) begin
          check("stall_hold_sum", oSum, h_s);
          check("stall_hold_carry", oC, h_c);
          check("stall_hold_valid", oValid, 1'b1);
          held = 1'b0;
        end
        check("ready_rule", oReady, (!oValid || iReady));
        if (oValid) begin
          if (q.size() == 0) begin
            check("unexpected_valid", oValid, 1'b0);
          end else begin
            check("sb_sum", oSum, q[0].s);
            check("sb_carry", oC, q[0].c);
          end
        end
        if (iRst) begin
          q.delete();
        end else begin
          if (oValid && iReady && q.size() != 0) begin
            void'(q.pop_front());
            n_out++;
          end
          if (iValid && oReady) q.push_back(model(iA, iB, iC, iMode));
          if (oValid && !iReady) begin
            held = 1'b1;
            h_s  = oSum;
            h_c  = oC;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   base, sent;

    r = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'd0);
    check("model_ripple", {r.s[55:0], r.c}, {56'd0, 8'h80});
    r = model(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b0, 2'd3);
    check("model_eighth", {r.s[55:0], r.c}, {56'd0, 8'hFF});
    r = model(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b0, 2'd0);
    check("model_full_sum", r.s, 64'h0101_0101_0101_0100);
    r = model(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 2'd1);
    check("model_half", {r.s[55:0], r.c}, {56'd0, 8'h08});
    r = model(64'd0, 64'd0, 1'b1, 2'd3);
    check("model_cin_eighth", r.s, 64'h0101_0101_0101_0101);

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
    iA = '0; iB = '0; iC = 1'b0; iMode = 2'd0;
    @(posedge iClk);
    #1;
    mon_on = 1;
    @(negedge iClk);
    check("rst_valid", oValid, 1'b0);
    check("rst_sum", oSum, 64'd0);
    check("rst_carry", oC, 8'd0);
    step();
    iRst = 1'b0;
    @(negedge iClk);
    check("rst_release_ready", oReady, 1'b1);
    step();

    run_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'd0, 64'd0, 8'h80);
    run_one("eighth", 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b0, 2'd3, 64'd0, 8'hFF);
    run_one("eighth_as_full", 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 1'b0, 2'd0,
            64'h0101_0101_0101_0100, 8'h80);
    run_one("half", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 2'd1, 64'd0, 8'h08);
    run_one("cin_full", 64'd0, 64'd0, 1'b1, 2'd0, 64'd1, 8'h00);
    run_one("cin_eighth", 64'd0, 64'd0, 1'b1, 2'd3, 64'h0101_0101_0101_0101, 8'h00);
    run_one("quarter_ff", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 8'hAA);

    // Back-pressure: six back-to-back transactions, three stalled cycles mid-stream.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'(i % 4));
      end
      begin
        repeat (5) @(posedge iClk);
        #1;
        iReady = 1'b0;
        @(negedge iClk);
        check("bp_ready_low", oReady, 1'b0);
        check("bp_valid_in_stall", oValid, 1'b1);
        repeat (3) @(posedge iClk);
        #1;
        iReady = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - base, 6);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 2'(i));
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    @(negedge iClk);
    check("midrst_valid", oValid, 1'b0);
    check("midrst_sum", oSum, 64'd0);
    check("midrst_carry", oC, 8'd0);
    check("midrst_ready", oReady, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      check("midrst_no_stale", oValid, 1'b0);
    end
    step();

    // Random traffic with random back-pressure and input gaps.
    base = n_out;
    sent = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [63:0] a, b;
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
          if ($urandom_range(0, 5) == 0) b = ~a;
          if ($urandom_range(0, 3) == 0) step();
          send(a, b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
          sent++;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge iClk);
          #1;
          if (!done) iReady = ($urandom_range(0, 9) < 7);
        end
      end
    join
    iReady = 1'b1;
    drain();
    check("rand_count", n_out - base, sent);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
